// File: rtl/instr_sequencer.sv
// instr_sequencer: loadable program memory that issues 16-bit instructions to a core over a run/done handshake
module instr_sequencer #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  input  logic              core_done,
  input  logic [15:0]       core_d_out,
  output logic [15:0]       instruction,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic [15:0]       last_result,
  output logic              result_valid,
  output logic              halted,
  output logic              error
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, HALT, ERROR} state_t;
  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   word;
  logic [CW-1:0] cnt;
  assign busy = (state == FETCH) || (state == ISSUE) || (state == WAIT);
  assign word = mem[pc];
  always_ff @(posedge clk)
    if (load_we && !busy) mem[load_addr] <= load_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      pc           <= '0;
      instruction  <= '0;
      run          <= 1'b0;
      last_result  <= '0;
      result_valid <= 1'b0;
      halted       <= 1'b0;
      error        <= 1'b0;
      cnt          <= '0;
    end else begin
      run          <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE, HALT, ERROR:
          if (start) begin
            state  <= FETCH;
            pc     <= '0;
            halted <= 1'b0;
            error  <= 1'b0;
          end
        FETCH: begin
          instruction <= word;
          // low bits 2'b11 mark the reserved HALT format, which is never issued
          if (&word[1:0]) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= ISSUE;
            run   <= 1'b1;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT:
          if (core_done) begin
            last_result  <= core_d_out;
            result_valid <= 1'b1;
            if (pc == ADDR_W'(DEPTH - 1)) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= ERROR;
            error <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenarios against a delay-programmable core model
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_we = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start = 1'b0;
  logic        core_done;
  logic [15:0] core_d_out;
  logic [15:0] instruction;
  logic        run;
  logic [4:0]  pc;
  logic        busy;
  logic [15:0] last_result;
  logic        result_valid;
  logic        halted;
  logic        error;
  int checks = 0;
  int errors = 0;
  int cm_delay = 0;
  int cm_left = 0;
  logic cm_done = 1'b0;
  logic hold_done = 1'b0;
  logic [15:0] d_val = '0;
  int n_run, n_rv, cyc, first_run, first_rv, first_err, run0_pc;
  logic [15:0] run0_instr, pc3_instr;

  instr_sequencer #(.DEPTH(32), .ADDR_W(5), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .core_done(core_done), .core_d_out(core_d_out), .instruction(instruction),
    .run(run), .pc(pc), .busy(busy), .last_result(last_result), .result_valid(result_valid),
    .halted(halted), .error(error)
  );

  always #5 clk = ~clk;
  assign core_done  = cm_done | hold_done;
  assign core_d_out = d_val;

  // core model: done rises cm_delay cycles after the run cycle; cm_delay 0 means never
  always @(posedge clk) begin
    cm_done <= 1'b0;
    if (run && cm_delay > 0) begin
      if (cm_delay == 1) cm_done <= 1'b1;
      else cm_left <= cm_delay - 1;
    end else if (cm_left > 0) begin
      cm_left <= cm_left - 1;
      if (cm_left == 1) cm_done <= 1'b1;
    end
  end

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // pulse start and sample every negedge until the sequencer goes idle or lim expires
  task automatic exec(input int lim, input bit meddle);
    n_run = 0; n_rv = 0; cyc = 0; first_run = -1; first_rv = -1; first_err = -1;
    run0_pc = -1; run0_instr = 'x; pc3_instr = 'x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_we = 1'b0;
    while (cyc < lim) begin
      if (run) begin
        if (n_run == 0) begin first_run = cyc; run0_instr = instruction; run0_pc = int'(pc); end
        if (pc == 5'd3) pc3_instr = instruction;
        n_run++;
      end
      if (result_valid) begin if (n_rv == 0) first_rv = cyc; n_rv++; end
      if (error && first_err < 0) first_err = cyc;
      if (!busy) break;
      if (meddle) begin
        load_addr = 5'd3; load_data = 16'hFFFF;
        load_we = (cyc == 5);
        start = (cyc == 5) || (cyc == 8);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; load_we = 1'b0;
    checks++; if (busy) begin errors++; $display("FAIL exec_bound busy still %b after %0d cycles, need 0", busy, lim); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if ({instruction, run, pc, busy} !== '0) begin errors++; $display("FAIL reset_core got instr=%h run=%b pc=%0d busy=%b, need all 0", instruction, run, pc, busy); end
    checks++; if ({last_result, result_valid, halted, error} !== '0) begin errors++; $display("FAIL reset_status got last=%h rv=%b halt=%b err=%b, need all 0", last_result, result_valid, halted, error); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load(5'd0, 16'h2404);
    load(5'd1, 16'h0003);
    cm_delay = 2; d_val = 16'h0011;
    exec(40, 1'b0);
    checks++; if (n_run !== 1) begin errors++; $display("FAIL basic_runs got %0d, need 1", n_run); end
    checks++; if (run0_instr !== 16'h2404 || run0_pc !== 0) begin errors++; $display("FAIL basic_issue got instr=%h pc=%0d, need 2404 pc 0", run0_instr, run0_pc); end
    checks++; if (first_run !== 1 || first_rv !== 4 || n_rv !== 1) begin errors++; $display("FAIL basic_timing got run@%0d rv@%0d nrv=%0d, need 1 4 1", first_run, first_rv, n_rv); end
    checks++; if (last_result !== 16'h0011) begin errors++; $display("FAIL basic_result got %h, need 0011", last_result); end
    checks++; if (halted !== 1'b1 || pc !== 5'd1 || cyc !== 5 || instruction !== 16'h0003) begin errors++; $display("FAIL basic_halt got halt=%b pc=%0d cyc=%0d instr=%h, need 1 1 5 0003", halted, pc, cyc, instruction); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 32; i++) load(5'(i), 16'h1000 | 16'(i << 2));
    cm_delay = 1; d_val = 16'h5A5A;
    exec(200, 1'b0);
    checks++; if (n_run !== 32 || n_rv !== 32) begin errors++; $display("FAIL fill_count got runs=%0d rv=%0d, need 32 32", n_run, n_rv); end
    checks++; if (halted !== 1'b1 || pc !== 5'd31 || error !== 1'b0) begin errors++; $display("FAIL fill_end got halt=%b pc=%0d err=%b, need 1 31 0", halted, pc, error); end
    checks++; if (cyc !== 96 || instruction !== 16'h107C || last_result !== 16'h5A5A) begin errors++; $display("FAIL fill_final got cyc=%0d instr=%h last=%h, need 96 107C 5A5A", cyc, instruction, last_result); end
  endtask

  task automatic test_timeout_busy;
    cm_delay = 0;
    exec(200, 1'b1);
    checks++; if (first_err - first_run !== 65) begin errors++; $display("FAIL timeout_delay got %0d samples run->error, need 65", first_err - first_run); end
    checks++; if (error !== 1'b1 || pc !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL timeout_state got err=%b pc=%0d busy=%b halt=%b, need 1 0 0 0", error, pc, busy, halted); end
    checks++; if (n_run !== 1 || n_rv !== 0) begin errors++; $display("FAIL busy_ignore got runs=%0d rv=%0d, need 1 0", n_run, n_rv); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (error !== 1'b0 || busy !== 1'b1 || pc !== 5'd0) begin errors++; $display("FAIL restart_clear got err=%b busy=%b pc=%0d, need 0 1 0", error, busy, pc); end
    @(negedge clk);
    checks++; if (run !== 1'b1 || instruction !== 16'h1000) begin errors++; $display("FAIL restart_issue got run=%b instr=%h, need 1 1000", run, instruction); end
    cm_delay = 1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exec(200, 1'b0);
    checks++; if (pc3_instr !== 16'h100C || n_run !== 32) begin errors++; $display("FAIL write_ignored got mem3=%h runs=%0d, need 100C 32", pc3_instr, n_run); end
  endtask

  task automatic test_reset_mid;
    cm_delay = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1 || last_result !== 16'h5A5A) begin errors++; $display("FAIL pre_reset got busy=%b last=%h, need 1 5A5A", busy, last_result); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({instruction, run, pc, busy, last_result, result_valid, halted, error} !== '0) begin errors++; $display("FAIL async_reset got instr=%h pc=%0d busy=%b last=%h, need all 0", instruction, pc, busy, last_result); end
    @(negedge clk);
    reset = 1'b0;
    cm_delay = 1;
    exec(200, 1'b0);
    checks++; if (n_run !== 32 || halted !== 1'b1 || pc !== 5'd31 || cyc !== 96) begin errors++; $display("FAIL rerun got runs=%0d halt=%b pc=%0d cyc=%0d, need 32 1 31 96", n_run, halted, pc, cyc); end
  endtask

  task automatic test_done_held;
    int rv_idle = 0;
    cm_delay = 0;
    load(5'd1, 16'h0003);
    hold_done = 1'b1; d_val = 16'hBEEF;
    repeat (3) begin @(negedge clk); if (result_valid) rv_idle++; end
    checks++; if (rv_idle !== 0 || last_result !== 16'h5A5A) begin errors++; $display("FAIL idle_done got rv=%0d last=%h, need 0 5A5A", rv_idle, last_result); end
    load_we = 1'b1; load_addr = 5'd0; load_data = 16'h0008;
    exec(40, 1'b0);
    hold_done = 1'b0;
    checks++; if (run0_instr !== 16'h0008) begin errors++; $display("FAIL load_with_start got instr=%h, need 0008", run0_instr); end
    checks++; if (n_run !== 1 || n_rv !== 1 || first_rv !== 3) begin errors++; $display("FAIL held_done got runs=%0d rv=%0d rv@%0d, need 1 1 3", n_run, n_rv, first_rv); end
    checks++; if (last_result !== 16'hBEEF || halted !== 1'b1 || pc !== 5'd1 || cyc !== 4) begin errors++; $display("FAIL held_end got last=%h halt=%b pc=%0d cyc=%0d, need BEEF 1 1 4", last_result, halted, pc, cyc); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_timeout_busy;
    test_reset_mid;
    test_done_held;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired with %0d errors so far", errors);
    $fatal(1, "watchdog");
  end
endmodule
